// File: rtl/alu_muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_muldiv_seq_pkg
// Purpose : Shared MDU op-code encodings, op-code width and FSM state type
//           for the iterative multiply/divide unit.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package alu_muldiv_seq_pkg;

  localparam int MDU_OP_WIDTH = 3;

  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULT  = 3'd0;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULTU = 3'd1;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIV   = 3'd2;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

endpackage : alu_muldiv_seq_pkg
`default_nettype wire

// File: rtl/alu_muldiv_seq_divstep.sv
`default_nettype none
// ============================================================================
// Module  : alu_muldiv_seq_divstep
// Purpose : One combinational restoring-divide step. Shifts the next dividend
//           bit into the partial remainder, trial-subtracts the divisor and
//           keeps the difference when it does not borrow.
// Ports   : rem      in  WIDTH  partial remainder (always < divisor when divisor != 0)
//           in_bit   in  1      next dividend bit, MSB first
//           divisor  in  WIDTH  divisor magnitude
//           rem_next out WIDTH  updated partial remainder
//           q_bit    out 1      quotient bit produced by this step
// Revision: 1.0 - initial release
// ============================================================================
module alu_muldiv_seq_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // One extra bit holds the borrow: the shifted remainder can reach
  // 2*divisor-1, which needs WIDTH+1 bits.
  assign diff     = {rem, in_bit} - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : {rem[WIDTH-2:0], in_bit};

endmodule : alu_muldiv_seq_divstep
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_muldiv_seq
// Purpose : Iterative radix-2 multiply/divide unit (MULT/MULTU/DIV/DIVU)
//           writing architectural HI/LO; also services MTHI/MTLO.
//           IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
// Ports   : clk      in  1      rising-edge clock
//           rst_n    in  1      asynchronous active-low reset
//           start    in  1      op request, honoured only while idle
//           op       in  OP_W   MULT=0 MULTU=1 DIV=2 DIVU=3 MTHI=4 MTLO=5
//           op1      in  WIDTH  rs operand (multiplicand/dividend/MT data)
//           op2      in  WIDTH  rt operand (multiplier/divisor)
//           flush    in  1      abort in-flight op / discard request
//           busy     out 1      operation in progress
//           done     out 1      one-cycle pulse, new HI/LO valid
//           div_zero out 1      last completed DIV/DIVU had op2 == 0
//           hi, lo   out WIDTH  HI / LO registers
// Revision: 1.0 - initial release
// ============================================================================
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6,
  parameter int OP_W  = MDU_OP_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  mdu_state_t       state;
  mdu_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;      // product high half / partial remainder
  logic [WIDTH-1:0] qr;       // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] dvs;      // multiplicand / divisor magnitude
  logic             run_div;  // operation in flight is a divide
  logic             neg_q;    // product or quotient must be negated
  logic             neg_r;    // remainder must be negated (dividend was negative)
  logic             dz_pend;  // divisor of the in-flight divide is zero

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo;
  logic op_signed, op_md, idle, md_req, mt_req;
  logic op1_neg, op2_neg;
  logic [WIDTH-1:0] op1_mag, op2_mag;

  assign is_mult   = (op == OP_W'(MDU_OP_MULT));
  assign is_multu  = (op == OP_W'(MDU_OP_MULTU));
  assign is_div    = (op == OP_W'(MDU_OP_DIV));
  assign is_divu   = (op == OP_W'(MDU_OP_DIVU));
  assign is_mthi   = (op == OP_W'(MDU_OP_MTHI));
  assign is_mtlo   = (op == OP_W'(MDU_OP_MTLO));

  assign op_signed = is_mult | is_div;
  assign op_md     = is_mult | is_multu | is_div | is_divu;
  assign idle      = (state == ST_IDLE);
  // flush squashes any request presented in the same cycle
  assign md_req    = idle & start & ~flush & op_md;
  assign mt_req    = idle & start & ~flush & (is_mthi | is_mtlo);

  assign op1_neg   = op_signed & op1[WIDTH-1];
  assign op2_neg   = op_signed & op2[WIDTH-1];
  // The most-negative value maps onto itself, which is the correct unsigned
  // magnitude 2**(WIDTH-1).
  assign op1_mag   = op1_neg ? (~op1 + 1'b1) : op1;
  assign op2_mag   = op2_neg ? (~op2 + 1'b1) : op2;

  // --------------------------------------------------------------------------
  // Per-step arithmetic
  // --------------------------------------------------------------------------
  // Shift-add multiply: conditionally add the multiplicand into the high half,
  // then shift {carry, acc, qr} right by one; the retired multiplier bit makes
  // room for the product bit falling out of acc.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] ds_rem;
  logic             ds_qbit;

  assign mul_sum = {1'b0, acc} + (qr[0] ? {1'b0, dvs} : {(WIDTH+1){1'b0}});

  alu_muldiv_seq_divstep #(
    .WIDTH (WIDTH)
  ) u_divstep (
    .rem      (acc),
    .in_bit   (qr[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (ds_rem),
    .q_bit    (ds_qbit)
  );

  // --------------------------------------------------------------------------
  // Sign correction applied in FIX
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               fix_wr;

  assign prod_fix = neg_q ? (~{acc, qr} + 1'b1) : {acc, qr};
  assign quo_fix  = neg_q ? (~qr + 1'b1) : qr;
  // With a zero divisor every trial subtraction succeeds without changing the
  // value, so acc ends up holding |op1|; re-applying the dividend sign gives
  // back the original op1 bits required in HI.
  assign rem_fix  = neg_r ? (~acc + 1'b1) : acc;
  assign fix_wr   = (state == ST_FIX) & ~flush;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (md_req) state_next = ST_RUN;
      ST_RUN: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      qr      <= '0;
      dvs     <= '0;
      run_div <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_pend <= 1'b0;
    end else if (md_req) begin
      cnt     <= CNT_W'(WIDTH);
      acc     <= '0;
      qr      <= op1_mag;
      dvs     <= op2_mag;
      run_div <= is_div | is_divu;
      neg_q   <= op1_neg ^ op2_neg;
      neg_r   <= is_div & op1_neg;
      dz_pend <= (is_div | is_divu) & (op2 == '0);
    end else if (state == ST_RUN) begin
      if (flush) begin
        cnt <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
        if (run_div) begin
          acc <= ds_rem;
          qr  <= {qr[WIDTH-2:0], ds_qbit};
        end else begin
          acc <= mul_sum[WIDTH:1];
          qr  <= {mul_sum[0], qr[WIDTH-1:1]};
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Architectural HI/LO and status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= fix_wr;
      busy <= (state_next != ST_IDLE);
      if (fix_wr) begin
        if (run_div) begin
          lo       <= dz_pend ? '1 : quo_fix;
          hi       <= rem_fix;
          div_zero <= dz_pend;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end else if (mt_req) begin
        if (is_mthi) begin
          hi <= op1;
        end else begin
          lo <= op1;
        end
      end
    end
  end

endmodule : alu_muldiv_seq
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_muldiv_seq
// Purpose : Self-checking bench for alu_muldiv_seq. Directed WIDTH=32 cases
//           (multiply, divide, divide-by-zero, MTHI/MTLO, flush, start while
//           busy, async reset) plus random ops on a WIDTH=16 and a WIDTH=32
//           instance checked against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  logic        s32_start = 1'b0, s32_flush = 1'b0;
  logic [2:0]  s32_op    = 3'd0;
  logic [31:0] s32_op1   = '0, s32_op2 = '0;
  logic        s32_busy, s32_done, s32_dz;
  logic [31:0] s32_hi, s32_lo;

  logic        s16_start = 1'b0, s16_flush = 1'b0;
  logic [2:0]  s16_op    = 3'd0;
  logic [15:0] s16_op1   = '0, s16_op2 = '0;
  logic        s16_busy, s16_done, s16_dz;
  logic [15:0] s16_hi, s16_lo;

  int tests = 0;
  int fails = 0;
  int n_done;
  logic        last_dz32 = 1'b0, last_dz16 = 1'b0;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, e_hi, e_lo;
  logic        e_dz;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(32), .CNT_W(6), .OP_W(3)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(s32_start), .op(s32_op), .op1(s32_op1),
    .op2(s32_op2), .flush(s32_flush), .busy(s32_busy), .done(s32_done),
    .div_zero(s32_dz), .hi(s32_hi), .lo(s32_lo)
  );

  alu_muldiv_seq #(.WIDTH(16), .CNT_W(5), .OP_W(3)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16_start), .op(s16_op), .op1(s16_op1),
    .op2(s16_op2), .flush(s16_flush), .busy(s16_busy), .done(s16_done),
    .div_zero(s16_dz), .hi(s16_hi), .lo(s16_lo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS multiply/divide semantics from plain integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int w, input logic prev_dz,
                                output logic [31:0] rhi, output logic [31:0] rlo,
                                output logic rdz);
    logic [63:0] mask, ua, ub, up;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = $signed(ua << (64 - w)) >>> (64 - w);
    sb   = $signed(ub << (64 - w)) >>> (64 - w);
    rdz  = prev_dz;
    up   = '0;
    if (op == MDU_OP_MULT || op == MDU_OP_MULTU) begin
      if (op == MDU_OP_MULT) up = sa * sb;
      else                   up = ua * ub;
      rhi = 32'((up >> w) & mask);
      rlo = 32'(up & mask);
    end else if (ub == 64'd0) begin
      rdz = 1'b1;
      rlo = 32'(mask);
      rhi = 32'(ua);
    end else begin
      rdz = 1'b0;
      if (op == MDU_OP_DIV) begin
        rlo = 32'(64'(sa / sb) & mask);
        rhi = 32'(64'(sa % sb) & mask);
      end else begin
        rlo = 32'((ua / ub) & mask);
        rhi = 32'((ua % ub) & mask);
      end
    end
  endfunction

  task automatic issue(input bit n16, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    if (n16) begin
      s16_start = 1'b1; s16_op = op; s16_op1 = a[15:0]; s16_op2 = b[15:0];
    end else begin
      s32_start = 1'b1; s32_op = op; s32_op1 = a; s32_op2 = b;
    end
    step();
    s16_start = 1'b0;
    s32_start = 1'b0;
  endtask

  // Waits (bounded) for done; checks latency and that busy stayed high.
  task automatic wait_done(input bit n16, input string tag, input int exp_lat);
    int lat = 999;
    int nbusy = 0;
    bit seen = 1'b0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      step();
      if ((n16 ? s16_done : s32_done) === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end else if ((n16 ? s16_busy : s32_busy) === 1'b1) begin
        nbusy++;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy cycles"}, 64'(nbusy), 64'(exp_lat - 1));
    chk({tag, " busy low at done"}, {63'd0, n16 ? s16_busy : s32_busy}, 64'd0);
  endtask

  task automatic op32(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ehi,
                      input logic [31:0] elo, input logic edz);
    issue(1'b0, op, a, b);
    chk({tag, " busy after start"}, {63'd0, s32_busy}, 64'd1);
    wait_done(1'b0, tag, 33);
    chk({tag, " hi"}, {32'd0, s32_hi}, {32'd0, ehi});
    chk({tag, " lo"}, {32'd0, s32_lo}, {32'd0, elo});
    chk({tag, " div_zero"}, {63'd0, s32_dz}, {63'd0, edz});
    step();
    chk({tag, " done pulse"}, {63'd0, s32_done}, 64'd0);
  endtask

  initial begin
    // ---------------- reset ----------------
    step();
    step();
    chk("rst busy32", {63'd0, s32_busy}, 64'd0);
    chk("rst done32", {63'd0, s32_done}, 64'd0);
    chk("rst dz32",   {63'd0, s32_dz},   64'd0);
    chk("rst hi32",   {32'd0, s32_hi},   64'd0);
    chk("rst lo32",   {32'd0, s32_lo},   64'd0);
    chk("rst busy16", {63'd0, s16_busy}, 64'd0);
    chk("rst hi16",   {48'd0, s16_hi},   64'd0);
    chk("rst lo16",   {48'd0, s16_lo},   64'd0);
    rst_n = 1'b1;
    step();

    // ---------------- MTHI / MTLO ----------------
    issue(1'b0, MDU_OP_MTHI, 32'hAAAA5555, 32'h0);
    chk("mthi hi", {32'd0, s32_hi}, 64'hAAAA5555);
    chk("mthi done", {63'd0, s32_done}, 64'd0);
    chk("mthi busy", {63'd0, s32_busy}, 64'd0);
    issue(1'b0, MDU_OP_MTLO, 32'h12345678, 32'h0);
    chk("mtlo lo", {32'd0, s32_lo}, 64'h12345678);
    chk("mtlo hi kept", {32'd0, s32_hi}, 64'hAAAA5555);
    s32_flush = 1'b1;
    issue(1'b0, MDU_OP_MTHI, 32'h0, 32'h0);
    s32_flush = 1'b0;
    chk("flushed mthi", {32'd0, s32_hi}, 64'hAAAA5555);
    issue(1'b0, 3'd7, 32'h5, 32'h6);
    chk("illegal op busy", {63'd0, s32_busy}, 64'd0);

    // ---------------- flush mid-MULT ----------------
    issue(1'b0, MDU_OP_MULT, 32'hFFFFFFFD, 32'd5);
    repeat (9) step();
    chk("pre-flush busy", {63'd0, s32_busy}, 64'd1);
    s32_flush = 1'b1;
    step();
    s32_flush = 1'b0;
    chk("flush busy", {63'd0, s32_busy}, 64'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (s32_done === 1'b1) n_done++;
    end
    chk("flush no done", 64'(n_done), 64'd0);
    chk("flush hi kept", {32'd0, s32_hi}, 64'hAAAA5555);
    chk("flush lo kept", {32'd0, s32_lo}, 64'h12345678);

    // ---------------- directed multiply / divide ----------------
    op32("mult -3*5",    MDU_OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    op32("multu max",    MDU_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    op32("divu 100/7",   MDU_OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);
    op32("div -7/2",     MDU_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    op32("div min/-1",   MDU_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    op32("div 1234/0",   MDU_OP_DIV,   32'd1234,     32'd0,        32'h000004D2, 32'hFFFFFFFF, 1'b1);
    op32("mult keeps dz", MDU_OP_MULT, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b1);
    op32("div -9/0",     MDU_OP_DIV,   32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1);
    op32("divu 9/3",     MDU_OP_DIVU,  32'd9,        32'd3,        32'h00000000, 32'h00000003, 1'b0);

    // ---------------- start while busy is ignored ----------------
    issue(1'b0, MDU_OP_MULTU, 32'd2, 32'd3);
    repeat (4) step();
    s32_start = 1'b1; s32_op = MDU_OP_MTHI; s32_op1 = 32'hDEADBEEF;
    step();
    s32_op = MDU_OP_DIVU; s32_op1 = 32'd100; s32_op2 = 32'd7;
    step();
    s32_start = 1'b0;
    wait_done(1'b0, "busy-ignore", 27);
    chk("busy-ignore hi", {32'd0, s32_hi}, 64'd0);
    chk("busy-ignore lo", {32'd0, s32_lo}, 64'd6);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (s32_done === 1'b1) n_done++;
    end
    chk("busy-ignore no replay", 64'(n_done), 64'd0);

    // ---------------- async reset mid-DIV ----------------
    issue(1'b0, MDU_OP_DIV, 32'd1000, 32'd3);
    repeat (10) step();
    chk("pre-reset busy", {63'd0, s32_busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", {63'd0, s32_busy}, 64'd0);
    chk("async rst hi",   {32'd0, s32_hi},   64'd0);
    chk("async rst lo",   {32'd0, s32_lo},   64'd0);
    #2 rst_n = 1'b1;
    last_dz32 = 1'b0;
    last_dz16 = 1'b0;
    step();
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (s32_done === 1'b1) n_done++;
    end
    chk("post-reset no done", 64'(n_done), 64'd0);

    // ---------------- random ops vs reference model ----------------
    for (int k = 0; k < 48; k++) begin
      bit n16;
      n16  = (k % 3) != 2;
      r_op = 3'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom;
      if (k % 8 == 3) r_b = 32'd0;
      if (k % 8 == 5) begin
        r_op = MDU_OP_DIV;
        r_a  = n16 ? 32'h00008000 : 32'h80000000;
        r_b  = 32'hFFFFFFFF;
      end
      if (k % 8 == 6) r_b = r_b & 32'h0000000F;
      if (n16) begin
        model(r_op, r_a, r_b, 16, last_dz16, e_hi, e_lo, e_dz);
        last_dz16 = e_dz;
        issue(1'b1, r_op, r_a, r_b);
        wait_done(1'b1, $sformatf("rnd16 #%0d op%0d", k, r_op), 17);
        chk($sformatf("rnd16 #%0d hi", k), {48'd0, s16_hi}, {32'd0, e_hi});
        chk($sformatf("rnd16 #%0d lo", k), {48'd0, s16_lo}, {32'd0, e_lo});
        chk($sformatf("rnd16 #%0d dz", k), {63'd0, s16_dz}, {63'd0, e_dz});
      end else begin
        model(r_op, r_a, r_b, 32, last_dz32, e_hi, e_lo, e_dz);
        last_dz32 = e_dz;
        issue(1'b0, r_op, r_a, r_b);
        wait_done(1'b0, $sformatf("rnd32 #%0d op%0d", k, r_op), 33);
        chk($sformatf("rnd32 #%0d hi", k), {32'd0, s32_hi}, {32'd0, e_hi});
        chk($sformatf("rnd32 #%0d lo", k), {32'd0, s32_lo}, {32'd0, e_lo});
        chk($sformatf("rnd32 #%0d dz", k), {63'd0, s32_dz}, {63'd0, e_dz});
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_alu_muldiv_seq
`default_nettype wire
